// File: rtl/matrix_loader.sv
// matrix_loader: collects n*n signed elements streamed in row-major order
// and presents them as one packed matrix bus to the determinant units.
// Element k = r*n+c occupies the byte k positions below the MSB end, and
// unused low bytes stay zero for matrices smaller than DIM_MAX.
module matrix_loader #(
    parameter int ELEM_W  = 8,
    parameter int DIM_MAX = 5
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic        [2:0]                          size,
    input  logic                                       in_valid,
    input  logic signed [ELEM_W-1:0]                   in_data,
    output logic                                       in_ready,
    output logic signed [DIM_MAX*DIM_MAX*ELEM_W-1:0]   matrix,
    output logic                                       mat_valid,
    input  logic                                       mat_ready,
    output logic                                       busy,
    output logic                                       err
);

    localparam int NELEM   = DIM_MAX * DIM_MAX;
    localparam int TOTAL_W = NELEM * ELEM_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    state_t               state_q;
    logic [4:0]           cnt_q;
    logic [4:0]           last_q;
    logic [TOTAL_W-1:0]   matrix_q;
    logic                 in_ready_q;
    logic                 mat_valid_q;
    logic                 busy_q;
    logic                 err_q;

    logic                 size_ok;
    logic [4:0]           last_idx_d;
    logic                 accept;
    logic [TOTAL_W-1:0]   matrix_d;

    // Decode start request and build the matrix image with the current element inserted
    always_comb begin
        size_ok    = (size >= 3'd2) && (size <= 3'(DIM_MAX));
        last_idx_d = 5'(size) * 5'(size) - 5'd1;
        accept     = in_ready_q & in_valid;
        matrix_d   = matrix_q;
        for (int unsigned i = 0; i < NELEM; i++) begin
            if (cnt_q == 5'(i)) begin
                matrix_d[TOTAL_W-1-ELEM_W*i -: ELEM_W] = in_data;
            end
        end
    end

    // Load sequencer with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            matrix_q    <= '0;
            in_ready_q  <= 1'b0;
            mat_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            matrix_q   <= '0;
                            cnt_q      <= '0;
                            last_q     <= last_idx_d;
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        matrix_q <= matrix_d;
                        if (cnt_q == last_q) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            mat_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (mat_ready) begin
                        state_q     <= IDLE;
                        mat_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    mat_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign matrix    = matrix_q;
    assign mat_valid = mat_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: randomized self-checking bench for matrix_loader.
// Expected matrices are built by shifting the element list into a bus.
module tb_matrix_loader;

    localparam int W = 200;

    logic                clk;
    logic                rst;
    logic                start;
    logic [2:0]          size;
    logic                in_valid;
    logic signed [7:0]   in_data;
    logic                in_ready;
    logic signed [W-1:0] matrix;
    logic                mat_valid;
    logic                mat_ready;
    logic                busy;
    logic                err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    matrix_loader #(
        .ELEM_W (8),
        .DIM_MAX(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .size     (size),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .matrix   (matrix),
        .mat_valid(mat_valid),
        .mat_ready(mat_ready),
        .busy     (busy),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bus: elements shifted in from the LSB end, zero-padded to 25 slots
    function automatic logic [W-1:0] pack(input int n, input logic [7:0] e[25]);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < 25; k++) begin
            r = {r[W-9:0], (k < n * n) ? e[k] : 8'h00};
        end
        return r;
    endfunction

    function automatic logic [3:0] status();
        return {busy, err, in_ready, mat_valid};
    endfunction

    task automatic run_load(input int n, input logic [7:0] e[25], input bit gaps,
                            output logic [W-1:0] exp);
        int k;
        exp   = pack(n, e);
        start = 1'b1;
        size  = 3'(n);
        tick();
        start = 1'b0;
        check_eq("load_entry_status", W'(status()), W'(4'b1010));
        check_eq("load_entry_clear", matrix, '0);
        k = 0;
        while (k < n * n) begin
            in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data   = e[k];
            start     = $urandom_range(0, 3) == 0;
            size      = 3'($urandom_range(0, 7));
            mat_ready = $urandom_range(0, 1);
            tick();
            if (in_valid) k++;
            if (k < n * n) check_eq("load_progress_status", W'(status()), W'(4'b1010));
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        mat_ready = 1'b0;
        check_eq("load_done_status", W'(status()), W'(4'b1001));
        check_eq("load_done_matrix", matrix, exp);
    endtask

    task automatic hold_release(input int cyc, input logic [W-1:0] exp, input bit start_on_release);
        for (int i = 0; i < cyc; i++) begin
            start = $urandom_range(0, 1);
            size  = 3'($urandom_range(0, 7));
            tick();
            check_eq("hold_status", W'(status()), W'(4'b1001));
            check_eq("hold_matrix", matrix, exp);
        end
        start     = start_on_release;
        size      = 3'd3;
        mat_ready = 1'b1;
        tick();
        start     = 1'b0;
        mat_ready = 1'b0;
        check_eq("release_status", W'(status()), W'(4'b0000));
        check_eq("release_matrix_kept", matrix, exp);
        tick();
        check_eq("idle_after_release", W'(status()), W'(4'b0000));
    endtask

    task automatic invalid_start(input logic [2:0] sz, input logic [W-1:0] prev);
        start = 1'b1;
        size  = sz;
        tick();
        start = 1'b0;
        check_eq("bad_size_err", W'(status()), W'(4'b0100));
        check_eq("bad_size_matrix", matrix, prev);
        tick();
        check_eq("bad_size_err_clear", W'(status()), W'(4'b0000));
    endtask

    initial begin
        logic [7:0]   e[25];
        logic [W-1:0] exp;
        logic [71:0]  top3;
        logic [23:0]  top5;
        int           n;

        rst = 1'b1; start = 1'b0; size = '0; in_valid = 1'b0;
        in_data = '0; mat_ready = 1'b0;
        tick();
        tick();
        check_eq("reset_status", W'(status()), W'(4'b0000));
        check_eq("reset_matrix", matrix, '0);
        rst = 1'b0;

        mat_ready = 1'b1;
        tick();
        mat_ready = 1'b0;
        check_eq("idle_mat_ready_ignored", W'(status()), W'(4'b0000));

        // 3x3 with elements 1..9, no gaps
        for (int k = 0; k < 25; k++) e[k] = 8'(k + 1);
        run_load(3, e, 1'b0, exp);
        top3 = 72'h010203040506070809;
        check_eq("3x3_top72", W'(matrix[199:128]), W'(top3));
        check_eq("3x3_low128", W'(matrix[127:0]), '0);
        hold_release(3, exp, 1'b1);

        invalid_start(3'd1, exp);
        invalid_start(3'd6, exp);
        invalid_start(3'd0, exp);
        invalid_start(3'd7, exp);

        // 5x5 signed values -k with gaps, then 20 cycles of backpressure
        for (int k = 0; k < 25; k++) e[k] = 8'(-k);
        run_load(5, e, 1'b1, exp);
        top5 = 24'h00FFFE;
        check_eq("5x5_top_bytes", W'(matrix[199:176]), W'(top5));
        check_eq("5x5_last_byte", W'(matrix[7:0]), W'(8'hE8));
        hold_release(20, exp, 1'b0);

        // reset after 7 of 16 elements of a 4x4, with competing start/handshake
        start = 1'b1;
        size  = 3'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        rst       = 1'b1;
        start     = 1'b1;
        mat_ready = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; mat_ready = 1'b0;
        check_eq("midload_reset_status", W'(status()), W'(4'b0000));
        check_eq("midload_reset_matrix", matrix, '0);
        for (int k = 0; k < 25; k++) e[k] = 8'($urandom);
        run_load(4, e, 1'b1, exp);
        check_eq("4x4_low72", W'(matrix[71:0]), '0);
        hold_release(2, exp, 1'b0);

        // reset while holding a complete matrix
        for (int k = 0; k < 25; k++) e[k] = 8'($urandom);
        run_load(2, e, 1'b0, exp);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("hold_reset_status", W'(status()), W'(4'b0000));
        check_eq("hold_reset_matrix", matrix, '0);

        // randomized loads
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(2, 5);
            for (int k = 0; k < 25; k++) e[k] = 8'($urandom);
            run_load(n, e, 1'($urandom_range(0, 1)), exp);
            hold_release($urandom_range(0, 4), exp, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) invalid_start(($urandom_range(0, 1) != 0) ? 3'd1 : 3'd6, exp);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ELEM_W, default 8, shall set the signed element width in bits.
REQ-002 Parameter DIM_MAX, default 5, shall set the maximum matrix order; the packed bus is DIM_MAX*DIM_MAX*ELEM_W = 200 bits.
REQ-003 Port clk shall be an input, 1 bit, and the single clock; every register updates on its rising edge.
REQ-004 Port rst shall be an input, 1 bit, and a synchronous active-high reset.
REQ-005 Port start shall be an input, 1 bit, requesting a new load in IDLE.
REQ-006 Port size shall be an input, 3 bits, giving the matrix order n; it is sampled with start.
REQ-007 Port in_valid shall be an input, 1 bit, marking in_data as valid.
REQ-008 Port in_data shall be an input, ELEM_W bits, signed, carrying one element in row-major order.
REQ-009 Port in_ready shall be an output, 1 bit, indicating that the block accepts an element.
REQ-010 Port matrix shall be an output, 200 bits, signed, carrying the packed matrix for the determinant units.
REQ-011 Port mat_valid shall be an output, 1 bit, indicating that matrix is complete and stable.
REQ-012 Port mat_ready shall be an input, 1 bit, indicating that the consumer has taken matrix.
REQ-013 Port busy shall be an output, 1 bit, high whenever the state is not IDLE.
REQ-014 Port err shall be an output, 1 bit, giving a one-cycle pulse when start is rejected.

Function
REQ-015 The FSM shall have exactly three states: IDLE, LOAD and HOLD.
REQ-016 In IDLE, start=1 with size in 2..5 shall latch n, clear matrix to 0, clear the element counter, and enter LOAD on the next cycle.
REQ-017 In IDLE, start=1 with size 0, 1, 6 or 7 shall pulse err for exactly one cycle, keep the state in IDLE, and leave matrix unchanged.
REQ-018 in_ready shall be 1 only in LOAD, driven from registered state without any combinational path from in_valid.
REQ-019 An element shall be accepted on a cycle where in_valid=1 and in_ready=1; an element with index k=r*n+c shall be written to matrix[199-8k -: 8], starting from row 0, column 0 at the MSBs.
REQ-020 For n<5, bits below the first n*n bytes shall remain 0, so the top 72 bits carry a 3x3, the top 128 bits a 4x4, and the top 32 bits a 2x2.
REQ-021 The counter shall be 5 bits wide; on acceptance of element n*n-1, the FSM shall enter HOLD and mat_valid shall be 1 on the next cycle, so latency from the last accept to mat_valid is 1 cycle.
REQ-022 in_valid=0 during LOAD shall stall the load with no state change and no timeout.
REQ-023 In HOLD, mat_valid=1 and matrix shall stay bit-stable until the cycle where mat_ready=1; the FSM shall then enter IDLE, and mat_valid shall be 0 on the next cycle.
REQ-024 A mat_ready=1 outside HOLD shall be ignored.
REQ-025 start shall be ignored in LOAD and HOLD with no err pulse; a start coinciding with the HOLD→IDLE handshake shall be ignored, and the earliest accepted restart is the following cycle.
REQ-026 matrix shall retain its last value in IDLE until the next accepted start clears it.
REQ-027 All arithmetic is index and packing only; element values shall be passed through bit-exactly with no sign change, saturation or overflow check.

Reset
REQ-028 On a clock edge with rst=1, the block shall set state=IDLE, counter=0, matrix=0, in_ready=0, mat_valid=0, busy=0 and err=0.
REQ-029 rst shall override start and every handshake in the same cycle.
REQ-030 A reset mid-LOAD or mid-HOLD shall discard the partial or complete matrix with no mat_valid pulse.

Verification
REQ-031 Bench scenario, 3x3 load: start with size=3, then elements 1..9 with in_valid held high shall give mat_valid=1 exactly 1 cycle after the 9th accept, matrix[199:128]=0x010203040506070809, matrix[127:0]=0, and in_ready=0 in HOLD.
REQ-032 Bench scenario, 5x5 load with signed values and random in_valid gaps: element k=-k shall pack as 0x00,0xFF,0xFE,...,0xE8 from MSB downward, with no element lost or duplicated.
REQ-033 Bench scenario, invalid size: start with size=1 and then with size=6 shall give err=1 for one cycle each, busy=0, and matrix unchanged.
REQ-034 Bench scenario, backpressure: mat_ready held 0 for 20 cycles after mat_valid shall keep matrix and mat_valid stable and ignore start; mat_ready=1 shall give mat_valid=0 and busy=0 on the next cycle.
REQ-035 Bench scenario, reset mid-load: rst=1 after 7 of 16 elements of a 4x4 shall give all outputs 0 next cycle; a fresh 4x4 load shall then complete correctly with matrix[71:0]=0.
